trng_sample_ctrl: RTL

//  Sequencer and word packer for the ring-oscillator/ring-generator TRNG core.
//  - Drives the core's enable and waits out a warm-up period.
//  - Samples the core's serial random bit through a 2-FF synchronizer and packs 32 bits into a word.
//  - Hands each word out on a valid/ready interface.
//  - Runs a continuous repetition-count health test and shuts the core down on a stuck source.

---
 rtl/trng_sample_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/trng_sample_ctrl.sv
// trng_sample_ctrl
//   Sequencer and word packer for the ring-oscillator TRNG core. It enables the
//   core, waits out a warm-up period, then samples the core's serial bit through
//   a two-flop synchronizer. Every SAMPLE_DIV clocks it takes one bit, and it
//   packs 32 bits (first bit in the MSB) into a word that is offered on a
//   valid/ready interface. A repetition-count health test runs on every sample.
//   If the source repeats the same value REP_LIMIT times in a row, the block
//   shuts the core down and latches a fault.
//
// Ports
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_start        pulse: begin generation (IDLE only)
//   i_stop         pulse: abort and return to IDLE from any state
//   i_rng_bit      raw TRNG bit, asynchronous to i_clk
//   i_ready        consumer ready for o_data
//   o_trng_en      enable to the TRNG core
//   o_data         packed 32-bit random word
//   o_valid        o_data valid
//   o_busy         controller not in IDLE
//   o_health_fail  sticky repetition-count fault flag (cleared by i_stop)
module trng_sample_ctrl #(
   parameter int WARMUP_CYCLES = 64,
   parameter int SAMPLE_DIV    = 4,
   parameter int REP_LIMIT     = 32
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic        i_stop,
   input  logic        i_rng_bit,
   input  logic        i_ready,
   output logic        o_trng_en,
   output logic [31:0] o_data,
   output logic        o_valid,
   output logic        o_busy,
   output logic        o_health_fail
);

   localparam int WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
   localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   // The run counter only ever holds 0..REP_LIMIT-1. The fault is raised on the
   // sample that would take it to REP_LIMIT, so the limit itself is never stored.
   localparam int RUN_W  = $clog2(REP_LIMIT);

   localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(REP_LIMIT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WARMUP,
      ST_COLLECT,
      ST_HOLD,
      ST_FAULT
   } state_t;

   state_t            state_reg;
   logic              sync1_reg;
   logic              sync2_reg;
   logic [WARM_W-1:0] warm_cnt_reg;
   logic [DIV_W-1:0]  div_cnt_reg;
   logic [4:0]        bit_cnt_reg;
   logic [RUN_W-1:0]  run_cnt_reg;
   logic              prev_bit_reg;
   logic [31:0]       shift_reg;

   logic              strobe;
   logic              same_bit;
   logic              rep_hit;
   logic              word_done;
   logic [RUN_W-1:0]  run_next;
   logic [31:0]       shift_next;

   // A run count of zero marks "no sample since warm-up". The first sample
   // therefore always starts a fresh run of length 1.
   assign strobe     = (div_cnt_reg == DIV_LAST);
   assign same_bit   = (run_cnt_reg != '0) && (sync2_reg == prev_bit_reg);
   assign rep_hit    = same_bit && (run_cnt_reg == RUN_LAST);
   assign run_next   = same_bit ? (run_cnt_reg + RUN_W'(1)) : RUN_W'(1);
   assign shift_next = {shift_reg[30:0], sync2_reg};
   assign word_done  = (bit_cnt_reg == 5'd31);

   // The synchronizer runs in every state, so the first sample after warm-up
   // already sees a settled bit.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
      end else begin
         sync1_reg <= i_rng_bit;
         sync2_reg <= sync1_reg;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg     <= ST_IDLE;
         warm_cnt_reg  <= '0;
         div_cnt_reg   <= '0;
         bit_cnt_reg   <= '0;
         run_cnt_reg   <= '0;
         prev_bit_reg  <= 1'b0;
         shift_reg     <= '0;
         o_trng_en     <= 1'b0;
         o_data        <= '0;
         o_valid       <= 1'b0;
         o_busy        <= 1'b0;
         o_health_fail <= 1'b0;
      end else if (i_stop) begin
         // Stop overrides everything, including a start in the same cycle.
         // Any partial word is dropped.
         state_reg     <= ST_IDLE;
         bit_cnt_reg   <= '0;
         shift_reg     <= '0;
         o_trng_en     <= 1'b0;
         o_valid       <= 1'b0;
         o_busy        <= 1'b0;
         o_health_fail <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (i_start) begin
                  state_reg    <= ST_WARMUP;
                  warm_cnt_reg <= '0;
                  o_trng_en    <= 1'b1;
                  o_busy       <= 1'b1;
               end
            end

            ST_WARMUP: begin
               div_cnt_reg <= '0;
               bit_cnt_reg <= '0;
               run_cnt_reg <= '0;
               shift_reg   <= '0;
               if (warm_cnt_reg == WARM_LAST) begin
                  state_reg <= ST_COLLECT;
               end else begin
                  warm_cnt_reg <= warm_cnt_reg + WARM_W'(1);
               end
            end

            ST_COLLECT: begin
               if (strobe) begin
                  div_cnt_reg  <= '0;
                  run_cnt_reg  <= run_next;
                  prev_bit_reg <= sync2_reg;
                  if (rep_hit) begin
                     // A fault beats word completion, so the word is never offered.
                     state_reg     <= ST_FAULT;
                     bit_cnt_reg   <= '0;
                     o_trng_en     <= 1'b0;
                     o_health_fail <= 1'b1;
                  end else if (word_done) begin
                     state_reg   <= ST_HOLD;
                     bit_cnt_reg <= '0;
                     o_data      <= shift_next;
                     o_valid     <= 1'b1;
                  end else begin
                     shift_reg   <= shift_next;
                     bit_cnt_reg <= bit_cnt_reg + 5'd1;
                  end
               end else begin
                  div_cnt_reg <= div_cnt_reg + DIV_W'(1);
               end
            end

            ST_HOLD: begin
               // Sampling pauses while the word waits; the run count carries over.
               if (i_ready) begin
                  state_reg   <= ST_COLLECT;
                  div_cnt_reg <= '0;
                  o_valid     <= 1'b0;
               end
            end

            ST_FAULT: begin
               o_trng_en <= 1'b0;
               o_valid   <= 1'b0;
            end

            default: begin
               state_reg <= ST_IDLE;
               o_trng_en <= 1'b0;
               o_valid   <= 1'b0;
               o_busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
